fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction fetch stage between the pc register and decode.
- Drives the pc register's next-address input.
- Addresses the synchronous instruction ROM using the pc register's current output.
- Buffers returned instructions in a small queue.
- Hands instructions to decode over a valid/ready handshake.
- Applies stall backpressure, branch redirect/flush, and halt-opcode stop.

Parameters:
AW, 8, address width; pc_in, next_pc, imem_addr, branch_target, out_pc.
IW, 16, instruction width.
DEPTH, 2, instruction queue entries; power of two, ≥2.
RESET_PC, 8'h00, next_pc driven while reset is asserted.
HALT_OP, 4'hF, opcode (instr[IW-1:IW-4]) that stops fetching.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
Reset  in  1  synchronous, active-low reset; 0 = reset.
pc_in  in  AW  current PC, from the pc register output.
next_pc  out  AW  next PC, to the pc register input.
imem_addr  out  AW  ROM address; combinational, equal to pc_in.
imem_rdata  in  IW  ROM data; valid one cycle after imem_addr.
branch_taken  in  1  redirect request from execute.
branch_target  in  AW  redirect address.
out_valid  out  1  queue head valid.
out_ready  in  1  decode accepts the head this cycle.
out_instr  out  IW  queue head instruction.
out_pc  out  AW  PC of the queue head instruction.
halted  out  1  high while in the HALTED state.

Behaviour:
- Definitions: pop = out_valid & out_ready. count = queue occupancy, 0..DEPTH. inflight = 1-bit flag, "ROM response due next cycle". inflight_pc = PC of that request.
- issue = state==RUN & !branch_taken & (count + inflight − pop < DEPTH).
- next_pc (combinational), in priority order:
  1. RESET_PC when Reset==0.
  2. branch_target when branch_taken.
  3. pc_in+1 when issue; wraps modulo 2^AW, so 8'hFF → 8'h00.
  4. pc_in otherwise (hold).
- Register update each edge:
  - inflight <= issue; inflight_pc <= pc_in.
  - When inflight==1 and there is no branch, push {imem_rdata, inflight_pc} to the queue tail.
  - Simultaneous push and pop is legal. count is unchanged, and the order is preserved.
  - ROM latency is exactly 1 cycle, so the data is consumed on the cycle it is valid.
- Outputs:
  - out_valid = count != 0.
  - out_instr and out_pc come from the queue head.
  - The head is stable while out_valid & !out_ready.
  - A handshake completes when out_valid & out_ready are both high on the same edge.
- FSM states: RUN, HALTED.
  - RUN → HALTED on the edge where a pushed instruction has opcode == HALT_OP. The halt instruction itself is queued and delivered normally. No issue in the following cycles.
  - HALTED: next_pc = pc_in, so the PC freezes. Already-queued instructions still drain. halted = 1.
  - HALTED → RUN only on branch_taken or reset.
- Branch (branch_taken==1): highest priority after reset.
  - Same edge: count <= 0, inflight <= 0, and that cycle's response is discarded. The pc register loads branch_target; state <= RUN.
  - out_valid falls on the following cycle.
  - A pop completed on the branch cycle counts as accepted.
  - Fetch from branch_target starts one cycle after the branch. First instruction: out_valid 2 cycles after the branch edge.
- Reset (Reset==0 at an edge):
  - count=0, inflight=0, state=RUN, queue pointers=0; next_pc=RESET_PC.
  - A mid-operation reset discards everything, including an inflight response.
  - Post-reset values: out_valid=0, halted=0, out_instr/out_pc = 0.
- Throughput: with out_ready held high, one instruction per cycle after 2 cycles of fill latency. The queue never overflows; the issue rule guarantees a slot for every response. Pushing when full is impossible by construction and is flagged by an assertion.

Decomposition:
- Shared package cpu_pkg:
  - AW and IW widths.
  - RESET_PC and HALT_OP constants.
  - Fetch FSM state encoding: RUN=1'b0, HALTED=1'b1.
- One sub-module: fetch_queue, a DEPTH-entry synchronous FIFO of {instr, pc}.
  - Inputs: push, pop, flush.
  - Outputs: count, head.
  - Built with registers only.

Test Plan:
- Reset held low 3 cycles, then released with pc register at 0, ROM[n]=16'h1000+n, out_ready=1 → next_pc=0 during reset. out_valid rises 2 cycles after release with out_pc=0, out_instr=16'h1000. Then one instruction per cycle: pc 1,2,3…
- Backpressure: out_ready=0 for 5 cycles mid-stream → count saturates at 2, next_pc holds, head is stable. On out_ready=1, delivery resumes in order with no skip or duplicate.
- Branch with queue full and a request inflight, branch_target=8'h40 → next cycle out_valid=0. The next delivered instruction has out_pc=8'h40, data=ROM[40].
- Wrap: PC reaches 8'hFF → next_pc=8'h00, and out_pc sequence is FE, FF, 00, 01.
- Halt: ROM[5]=16'hF000 → instructions 0..5 are delivered, halted=1, and pc_in freezes. A later branch to 8'h10 clears halted and fetches from 8'h10.
- Reset asserted during a branch cycle with inflight=1 → reset wins: next_pc=RESET_PC, queue empty, no stale instruction delivered after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared widths, constants and types for the instruction fetch stage.
package cpu_pkg;

   localparam int AW          = 8;
   localparam int IW          = 16;
   localparam int FETCH_DEPTH = 2;

   localparam logic [AW-1:0] RESET_PC = 8'h00;
   localparam logic [3:0]    HALT_OP  = 4'hF;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [IW-1:0] instr;
      logic [AW-1:0] pc;
   } fetch_entry_t;

   function automatic logic [3:0] opcode_of(input logic [IW-1:0] instr);
      return instr[IW-1 -: 4];
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: pc register, instruction ROM, branch redirect and decode handshake.
interface fetch_unit_if;
   import cpu_pkg::*;

   logic [AW-1:0] pc_in;
   logic [AW-1:0] next_pc;
   logic [AW-1:0] imem_addr;
   logic [IW-1:0] imem_rdata;
   logic          branch_taken;
   logic [AW-1:0] branch_target;
   logic          out_valid;
   logic          out_ready;
   logic [IW-1:0] out_instr;
   logic [AW-1:0] out_pc;
   logic          halted;

   // master: the fetch unit itself; slave: pc register, ROM, execute and decode
   modport master (
      input  pc_in, imem_rdata, branch_taken, branch_target, out_ready,
      output next_pc, imem_addr, out_valid, out_instr, out_pc, halted
   );

   modport slave (
      output pc_in, imem_rdata, branch_taken, branch_target, out_ready,
      input  next_pc, imem_addr, out_valid, out_instr, out_pc, halted
   );

endinterface

// File: rtl/fetch_queue.sv
// Register-based FIFO of {instr, pc} with flush; head is always visible.
module fetch_queue
   import cpu_pkg::*;
#(
   parameter  int DEPTH = FETCH_DEPTH,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic         i_flush,
   input  fetch_entry_t i_entry,
   output logic [CW-1:0] o_count,
   output fetch_entry_t o_head
);

   fetch_entry_t  r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;

   // flush overrides both sides, so a push on the flush edge is dropped
   assign w_push = i_push & ~i_flush;
   assign w_pop  = i_pop & ~i_flush & (r_count != '0);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_push) begin
         r_mem[r_wr_ptr] <= i_entry;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];

   a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      w_push |-> (r_count != CW'(DEPTH)));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: drives the pc register, reads the 1-cycle ROM, queues and hands off to decode.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int DEPTH = FETCH_DEPTH
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   fetch_unit_if.master  io_fetch
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_e  r_state;
   logic          r_inflight;
   logic [AW-1:0] r_inflight_pc;

   logic [CW-1:0] w_count;
   logic [CW:0]   w_occupancy;
   fetch_entry_t  w_head;
   fetch_entry_t  w_push_entry;
   logic          w_valid;
   logic          w_pop;
   logic          w_issue;
   logic          w_push;
   logic          w_halt_push;
   logic [AW-1:0] w_next_pc;

   assign w_valid = (w_count != '0);
   assign w_pop   = w_valid & io_fetch.out_ready;

   // only issue when the response is guaranteed a queue slot on arrival
   assign w_occupancy = {1'b0, w_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
   assign w_issue     = (r_state == RUN) & ~io_fetch.branch_taken
                        & (w_occupancy < (CW+1)'(DEPTH));

   // a response that arrives after halt has been taken is past the halt and is dropped
   assign w_push       = r_inflight & ~io_fetch.branch_taken & (r_state == RUN);
   assign w_halt_push  = w_push & (opcode_of(io_fetch.imem_rdata) == HALT_OP);
   assign w_push_entry = '{instr: io_fetch.imem_rdata, pc: r_inflight_pc};

   always_comb begin
      w_next_pc = io_fetch.pc_in;
      if (!i_rst_n) begin
         w_next_pc = RESET_PC;
      end else if (io_fetch.branch_taken) begin
         w_next_pc = io_fetch.branch_target;
      end else if (w_issue) begin
         w_next_pc = io_fetch.pc_in + AW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state       <= RUN;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
      end else begin
         r_inflight    <= w_issue;
         r_inflight_pc <= io_fetch.pc_in;
         if (io_fetch.branch_taken) begin
            r_state <= RUN;
         end else if (w_halt_push) begin
            r_state <= HALTED;
         end
      end
   end

   fetch_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (io_fetch.branch_taken),
      .i_entry (w_push_entry),
      .o_count (w_count),
      .o_head  (w_head)
   );

   assign io_fetch.next_pc   = w_next_pc;
   assign io_fetch.imem_addr = io_fetch.pc_in;
   assign io_fetch.out_valid = w_valid;
   assign io_fetch.out_instr = w_head.instr;
   assign io_fetch.out_pc    = w_head.pc;
   assign io_fetch.halted    = (r_state == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: pc register and ROM models, directed scenarios, random traffic, scoreboard.
module tb_fetch_unit;
   import cpu_pkg::*;

   typedef struct {
      logic [AW-1:0] pc;
      logic [IW-1:0] instr;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [IW-1:0] rom [256];
   logic [AW-1:0] pc_reg;
   logic [IW-1:0] rom_q;

   int checks = 0;
   int errors = 0;
   int delivered = 0;

   exp_t          exp_q[$];
   logic [AW-1:0] gen_pc;
   logic          gen_stop;

   fetch_unit_if bus();

   fetch_unit dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n),
      .io_fetch (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      pc_reg <= bus.next_pc;
      rom_q  <= rom[bus.imem_addr];
   end
   assign bus.pc_in      = pc_reg;
   assign bus.imem_rdata = rom_q;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference: the delivered stream is the program-order walk from the last
   // reset/branch address, stopping after the first halt opcode.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         exp_q.delete();
         gen_pc   = RESET_PC;
         gen_stop = 1'b0;
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_delivery actual=pc %0h required=none", bus.out_pc);
            end else begin
               e = exp_q.pop_front();
               $display("pop pc=%02h instr=%04h", bus.out_pc, bus.out_instr);
               check("deliver_pc", bus.out_pc, e.pc);
               check("deliver_instr", bus.out_instr, e.instr);
            end
            delivered++;
         end
         if (bus.branch_taken) begin
            exp_q.delete();
            gen_pc   = bus.branch_target;
            gen_stop = 1'b0;
         end
         while (exp_q.size() < 4 && !gen_stop) begin
            e.pc    = gen_pc;
            e.instr = rom[gen_pc];
            exp_q.push_back(e);
            if (e.instr[IW-1 -: 4] == 4'hF) gen_stop = 1'b1;
            gen_pc = gen_pc + 8'd1;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_branch(input logic [AW-1:0] target);
      bus.branch_taken  = 1'b1;
      bus.branch_target = target;
      cyc();
      bus.branch_taken  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [AW-1:0] hold_pc;
      logic [AW-1:0] head_pc;
      logic [IW-1:0] head_instr;
      int d0;
      int waited;

      rst_n             = 1'b0;
      bus.out_ready     = 1'b1;
      bus.branch_taken  = 1'b0;
      bus.branch_target = '0;
      for (int n = 0; n < 256; n++) rom[n] = 16'h1000 + 16'(n);
      rom[5] = 16'hF000;

      // reset state and fill latency
      repeat (3) cyc();
      #1;
      check("reset_next_pc", bus.next_pc, RESET_PC);
      check("reset_out_valid", bus.out_valid, 0);
      check("reset_halted", bus.halted, 0);
      check("reset_out_instr", bus.out_instr, 0);
      check("reset_out_pc", bus.out_pc, 0);
      rst_n = 1'b1;
      #1;
      check("release_next_pc", bus.next_pc, 1);
      cyc();
      check("fill_cycle1_valid", bus.out_valid, 0);
      cyc();
      check("fill_cycle2_valid", bus.out_valid, 1);
      check("first_pc", bus.out_pc, 0);
      check("first_instr", bus.out_instr, 16'h1000);

      // halt at ROM[5]
      waited = 0;
      while (!bus.halted && waited < 40) begin
         cyc();
         waited++;
      end
      check("halt_reached", bus.halted, 1);
      hold_pc = bus.pc_in;
      repeat (4) cyc();
      check("halt_pc_frozen", bus.pc_in, hold_pc);
      check("halt_next_pc_hold", bus.next_pc, hold_pc);
      check("halt_drained", bus.out_valid, 0);

      // branch out of HALTED
      do_branch(8'h10);
      check("unhalt_by_branch", bus.halted, 0);
      check("branch_valid_drop", bus.out_valid, 0);
      cyc();
      check("branch_plus1_valid", bus.out_valid, 0);
      cyc();
      check("branch_plus2_valid", bus.out_valid, 1);
      check("branch_first_pc", bus.out_pc, 8'h10);

      // one per cycle throughput
      d0 = delivered;
      repeat (6) cyc();
      check("throughput_6cyc", delivered - d0, 6);

      // backpressure
      bus.out_ready = 1'b0;
      repeat (2) cyc();
      head_pc    = bus.out_pc;
      head_instr = bus.out_instr;
      hold_pc    = bus.pc_in;
      repeat (3) begin
         cyc();
         check("stall_valid", bus.out_valid, 1);
         check("stall_head_pc", bus.out_pc, head_pc);
         check("stall_head_instr", bus.out_instr, head_instr);
         check("stall_pc_hold", bus.pc_in, hold_pc);
         check("stall_next_pc_hold", bus.next_pc, hold_pc);
      end
      bus.out_ready = 1'b1;
      repeat (4) cyc();

      // branch with a stalled, occupied queue and a response in flight
      bus.out_ready = 1'b0;
      do_branch(8'h40);
      check("flush_valid_drop", bus.out_valid, 0);
      bus.out_ready = 1'b1;
      cyc();
      check("flush_plus1_valid", bus.out_valid, 0);
      cyc();
      check("flush_plus2_valid", bus.out_valid, 1);
      check("flush_first_pc", bus.out_pc, 8'h40);
      check("flush_first_instr", bus.out_instr, rom[8'h40]);
      repeat (3) cyc();

      // PC wrap
      do_branch(8'hFC);
      waited = 0;
      while (bus.pc_in != 8'hFF && waited < 20) begin
         cyc();
         waited++;
      end
      check("wrap_pc_in", bus.pc_in, 8'hFF);
      check("wrap_next_pc", bus.next_pc, 8'h00);
      waited = 0;
      while (!bus.halted && waited < 40) begin
         cyc();
         waited++;
      end
      check("wrap_then_halt", bus.halted, 1);

      // reset coinciding with a branch while a response is in flight
      do_branch(8'h30);
      cyc();
      rst_n             = 1'b0;
      bus.branch_taken  = 1'b1;
      bus.branch_target = 8'h77;
      #1;
      check("reset_beats_branch_next_pc", bus.next_pc, RESET_PC);
      cyc();
      bus.branch_taken = 1'b0;
      check("midreset_valid", bus.out_valid, 0);
      check("midreset_halted", bus.halted, 0);
      check("midreset_pc_in", bus.pc_in, RESET_PC);
      cyc();
      rst_n = 1'b1;
      repeat (12) cyc();

      // random traffic against fresh ROM contents
      rst_n = 1'b0;
      for (int n = 0; n < 256; n++) rom[n] = 16'($urandom);
      repeat (2) cyc();
      rst_n = 1'b1;
      d0 = delivered;
      for (int c = 0; c < 600; c++) begin
         bus.out_ready = ($urandom_range(3) != 0);
         if ($urandom_range(15) == 0) begin
            bus.branch_taken  = 1'b1;
            bus.branch_target = 8'($urandom);
         end else begin
            bus.branch_taken  = 1'b0;
         end
         cyc();
      end
      bus.branch_taken = 1'b0;
      bus.out_ready    = 1'b1;
      repeat (10) cyc();
      check("random_progress", (delivered - d0) > 100, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
